// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C register-access sequencer: FSM states, status codes,
// R/W address bit values and the byte-controller command bundle.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEVW,
        REG,
        WDAT,
        RDEV,
        RDAT,
        STOP,
        FIN
    } state_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_NACK = 2'd1,
        ST_AL   = 2'd2,
        ST_TMO  = 2'd3
    } status_e;

    localparam logic RW_W = 1'b0;
    localparam logic RW_R = 1'b1;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic       ack_in;
        logic [7:0] din;
    } bc_cmd_t;

    localparam bc_cmd_t CMD_NONE = '0;

endpackage

// File: rtl/i2c_master_reg_seq_if.sv
// Request, read-data, completion and byte-controller command signals of the sequencer.
// master = the sequencer itself; slave = requester plus byte controller.
interface i2c_master_reg_seq_if #(
    parameter int unsigned LEN_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_rnw;
    logic [6:0]       req_dev;
    logic [7:0]       req_reg;
    logic [7:0]       req_wdata;
    logic [LEN_W-1:0] req_len;

    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             done;
    logic [1:0]       status;

    logic             bc_start;
    logic             bc_stop;
    logic             bc_read;
    logic             bc_write;
    logic             bc_ack_in;
    logic [7:0]       bc_din;
    logic             bc_cmd_ack;
    logic             bc_ack_out;
    logic [7:0]       bc_dout;
    logic             bc_al;

    modport master (
        input  req_valid, req_rnw, req_dev, req_reg, req_wdata, req_len,
        input  bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
        output req_ready, rd_valid, rd_data, done, status,
        output bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
    );

    modport slave (
        output req_valid, req_rnw, req_dev, req_reg, req_wdata, req_len,
        output bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
        input  req_ready, rd_valid, rd_data, done, status,
        input  bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
    );
endinterface

// File: rtl/i2c_seq_wdog.sv
// Per-command watchdog: counts cycles while a byte command is pending and flags
// expiry after TIMEOUT_CYC cycles. Instantiated only with I2C_SEQ_TIMEOUT_EN.
module i2c_seq_wdog #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pend,
    output logic o_expired
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    // Idle cycles between commands clear the count, so every newly issued command starts from zero.
    always_ff @(posedge clk) begin
        if (rst || !i_pend) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_pend && (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/i2c_master_reg_seq.sv
// I2C register-access sequencer: expands one register read/write request into
// byte-controller commands. Optional watchdog under macro I2C_SEQ_TIMEOUT_EN
// (adds parameter TIMEOUT_CYC).
module i2c_master_reg_seq
    import i2c_seq_pkg::*;
#(
    parameter int unsigned LEN_W = 4
`ifdef I2C_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_master_reg_seq_if.master bus
);

    state_e           r_state,     w_state_nxt;
    logic             r_pend,      w_pend_nxt;
    bc_cmd_t          r_cmd,       w_cmd_nxt,   w_this_cmd;
    logic [LEN_W-1:0] r_cnt,       w_cnt_nxt;
    status_e          r_status,    w_status_nxt;
    logic             r_rd_valid,  w_rd_valid_nxt;
    logic [7:0]       r_rd_data,   w_rd_data_nxt;
    logic             r_done,      w_done_nxt;
    status_e          r_status_o,  w_status_o_nxt;
    logic             r_ready;

    logic             r_rnw;
    logic [6:0]       r_dev;
    logic [7:0]       r_reg;
    logic [7:0]       r_wdata;

    logic             w_accept;
    logic             w_last;
    logic             w_tmo;

    assign w_accept = (r_state == IDLE) && bus.req_valid && r_ready;
    assign w_last   = (r_cnt == '0);

`ifdef I2C_SEQ_TIMEOUT_EN
    i2c_seq_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_pend    (r_pend),
        .o_expired (w_tmo)
    );
`else
    assign w_tmo = 1'b0;
`endif

    // Command each byte state issues once its idle cycle has passed.
    always_comb begin
        w_this_cmd = CMD_NONE;
        case (r_state)
            DEVW: begin
                w_this_cmd.start = 1'b1;
                w_this_cmd.write = 1'b1;
                w_this_cmd.din   = {r_dev, RW_W};
            end
            REG: begin
                w_this_cmd.write = 1'b1;
                w_this_cmd.din   = r_reg;
            end
            WDAT: begin
                w_this_cmd.write = 1'b1;
                w_this_cmd.stop  = 1'b1;
                w_this_cmd.din   = r_wdata;
            end
            RDEV: begin
                w_this_cmd.start = 1'b1;
                w_this_cmd.write = 1'b1;
                w_this_cmd.din   = {r_dev, RW_R};
            end
            RDAT: begin
                w_this_cmd.read   = 1'b1;
                w_this_cmd.ack_in = w_last;
                w_this_cmd.stop   = w_last;
            end
            STOP: begin
                w_this_cmd.stop = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: every signal gets its hold/idle value first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend;
        w_cmd_nxt      = r_cmd;
        w_cnt_nxt      = r_cnt;
        w_status_nxt   = r_status;
        w_rd_valid_nxt = 1'b0;
        w_rd_data_nxt  = r_rd_data;
        w_done_nxt     = 1'b0;
        w_status_o_nxt = ST_OK;

        if (r_state == IDLE) begin
            if (w_accept) begin
                w_state_nxt  = DEVW;
                w_cnt_nxt    = bus.req_len;
                w_status_nxt = ST_OK;
            end
        end else if (r_state == FIN) begin
            w_done_nxt     = 1'b1;
            w_status_o_nxt = r_status;
            w_state_nxt    = IDLE;
        end else if (bus.bc_al) begin
            // Bus lost: drop everything, no STOP attempt.
            w_cmd_nxt    = CMD_NONE;
            w_pend_nxt   = 1'b0;
            w_status_nxt = ST_AL;
            w_state_nxt  = FIN;
        end else if (w_tmo && !bus.bc_cmd_ack) begin
            w_cmd_nxt    = CMD_NONE;
            w_pend_nxt   = 1'b0;
            w_status_nxt = ST_TMO;
            w_state_nxt  = FIN;
        end else if (!r_pend) begin
            w_cmd_nxt  = w_this_cmd;
            w_pend_nxt = 1'b1;
        end else if (bus.bc_cmd_ack) begin
            w_cmd_nxt  = CMD_NONE;
            w_pend_nxt = 1'b0;
            case (r_state)
                DEVW, RDEV: begin
                    if (bus.bc_ack_out) begin
                        w_status_nxt = ST_NACK;
                        w_state_nxt  = STOP;
                    end else begin
                        w_state_nxt = (r_state == DEVW) ? REG : RDAT;
                    end
                end
                REG: begin
                    if (bus.bc_ack_out) begin
                        w_status_nxt = ST_NACK;
                        w_state_nxt  = STOP;
                    end else begin
                        w_state_nxt = r_rnw ? RDEV : WDAT;
                    end
                end
                WDAT: begin
                    if (bus.bc_ack_out) begin
                        w_status_nxt = ST_NACK;
                    end
                    w_state_nxt = FIN;
                end
                RDAT: begin
                    w_rd_valid_nxt = 1'b1;
                    w_rd_data_nxt  = bus.bc_dout;
                    if (w_last) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: w_state_nxt = FIN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pend     <= 1'b0;
            r_cmd      <= CMD_NONE;
            r_cnt      <= '0;
            r_status   <= ST_OK;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
            r_status_o <= ST_OK;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_cmd      <= w_cmd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_status   <= w_status_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_done     <= w_done_nxt;
            r_status_o <= w_status_o_nxt;
            r_ready    <= (w_state_nxt == IDLE);
        end
    end

    // NOTE: request fields are datapath captures with no reset; they are only read after an accept reloads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rnw   <= bus.req_rnw;
            r_dev   <= bus.req_dev;
            r_reg   <= bus.req_reg;
            r_wdata <= bus.req_wdata;
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.done      = r_done;
    assign bus.status    = r_status_o;
    assign bus.bc_start  = r_cmd.start;
    assign bus.bc_stop   = r_cmd.stop;
    assign bus.bc_read   = r_cmd.read;
    assign bus.bc_write  = r_cmd.write;
    assign bus.bc_ack_in = r_cmd.ack_in;
    assign bus.bc_din    = r_cmd.din;

endmodule

// File: tb/tb_i2c_master_reg_seq.sv
// Scoreboard bench for i2c_master_reg_seq: a byte-controller model answers commands,
// a transaction-level reference predicts commands, read bytes and final status.
module tb_i2c_master_reg_seq;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned TMO   = 100;

    typedef logic [12:0] cmd_t;   // {start, stop, read, write, ack_in, din}

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_rd[$];
    logic [1:0] exp_done[$];
    logic [7:0] slave_bytes[$];
    logic [7:0] preset[$];

    int plan_nack = -1;
    int plan_al   = -1;
    int cmd_idx   = 0;
    bit withhold  = 1'b0;
    bit poke_al   = 1'b0;
    int rd_count  = 0;

    i2c_master_reg_seq_if #(.LEN_W(LEN_W)) bus ();

    i2c_master_reg_seq #(
        .LEN_W (LEN_W)
`ifdef I2C_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYC (TMO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input bit s, input bit p, input bit r, input bit w,
                                input bit a, input logic [7:0] d);
        return {s, p, r, w, a, d};
    endfunction

    function automatic cmd_t dut_cmd();
        return {bus.bc_start, bus.bc_stop, bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.bc_din};
    endfunction

    // Byte-controller model: compares each new command, holds it a random time, then acks.
    initial begin : bc_model
        bit   busy     = 1'b0;
        bit   post_ack = 1'b0;
        int   left     = 0;
        cmd_t held     = '0;
        cmd_t e;
        cmd_t m;
        bus.bc_cmd_ack = 1'b0;
        bus.bc_ack_out = 1'b0;
        bus.bc_al      = 1'b0;
        bus.bc_dout    = 8'h00;
        forever begin
            @(negedge clk);
            bus.bc_cmd_ack = 1'b0;
            bus.bc_ack_out = 1'b0;
            bus.bc_al      = 1'b0;
            if (rst) begin
                busy     = 1'b0;
                post_ack = 1'b0;
            end else if (post_ack) begin
                check("cmd_cleared_after_ack", 32'(dut_cmd()), 32'd0);
                post_ack = 1'b0;
            end else if (!busy) begin
                if (dut_cmd() != '0) begin
                    busy = 1'b1;
                    held = dut_cmd();
                    left = $urandom_range(0, 3);
                    if (exp_cmd.size() == 0) begin
                        check("cmd_extra", 32'(dut_cmd()), 32'd0);
                    end else begin
                        e = exp_cmd.pop_front();
                        m = e[9] ? 13'h1fff : 13'h1f00;
                        check("cmd_seq", 32'(dut_cmd() & m), 32'(e & m));
                    end
                end else if (poke_al) begin
                    bus.bc_al = 1'b1;
                    poke_al   = 1'b0;
                end
            end else if (withhold) begin
                if (dut_cmd() == '0) busy = 1'b0;
            end else begin
                check("cmd_hold", 32'(dut_cmd()), 32'(held));
                if (left == 0) begin
                    bus.bc_cmd_ack = 1'b1;
                    bus.bc_ack_out = held[10] ? 1'($urandom_range(0, 1)) : (cmd_idx == plan_nack);
                    bus.bc_al      = (cmd_idx == plan_al);
                    if (held[10]) bus.bc_dout = (slave_bytes.size() != 0) ? slave_bytes.pop_front() : 8'h00;
                    cmd_idx++;
                    busy     = 1'b0;
                    post_ack = 1'b1;
                end else begin
                    left--;
                end
            end
        end
    end

    // Output monitor: pops read-byte and completion expectations as the DUT presents them.
    initial begin : monitor
        logic [7:0] b;
        logic [1:0] s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rd_valid) begin
                    rd_count++;
                    if (exp_rd.size() == 0) begin
                        check("rd_extra_strobe", 32'(bus.rd_valid), 32'd0);
                    end else begin
                        b = exp_rd.pop_front();
                        check("rd_data", 32'(bus.rd_data), 32'(b));
                    end
                end
                if (bus.done) begin
                    if (exp_done.size() == 0) begin
                        check("done_extra", 32'(bus.done), 32'd0);
                    end else begin
                        s = exp_done.pop_front();
                        check("done_status", 32'(bus.status), 32'(s));
                        check("done_cmds_left", 32'(exp_cmd.size()), 32'd0);
                        check("done_rd_left", 32'(exp_rd.size()), 32'd0);
                    end
                end
            end
        end
    end

    // Transaction-level reference: full byte list, then truncated by the planned NACK / AL.
    task automatic run_txn(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [LEN_W-1:0] len,
                           input int nack_at, input int al_at, input bit wait_done);
        cmd_t       base[$];
        logic [1:0] st;
        logic [7:0] b;
        int         t;
        base.push_back(mk(1, 0, 0, 1, 0, {dev, 1'b0}));
        base.push_back(mk(0, 0, 0, 1, 0, rg));
        if (!rnw) begin
            base.push_back(mk(0, 1, 0, 1, 0, wd));
        end else begin
            base.push_back(mk(1, 0, 0, 1, 0, {dev, 1'b1}));
            for (int k = 0; k <= int'(len); k++) base.push_back(mk(0, k == int'(len), 1, 0, k == int'(len), 8'h00));
        end
        st = 2'd0;
        for (int i = 0; i < base.size(); i++) begin
            exp_cmd.push_back(base[i]);
            if (i == al_at) begin
                st = 2'd2;
                break;
            end
            if (base[i][10]) begin
                b = (preset.size() != 0) ? preset.pop_front() : 8'($urandom);
                slave_bytes.push_back(b);
                exp_rd.push_back(b);
            end else if (i == nack_at) begin
                st = 2'd1;
                if (!base[i][11]) exp_cmd.push_back(mk(0, 1, 0, 0, 0, 8'h00));
                break;
            end
        end
        exp_done.push_back(st);

        @(negedge clk);
        t = 0;
        while (!bus.req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        plan_nack     = nack_at;
        plan_al       = al_at;
        cmd_idx       = 0;
        bus.req_rnw   = rnw;
        bus.req_dev   = dev;
        bus.req_reg   = rg;
        bus.req_wdata = wd;
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
        if (wait_done) begin
            t = 0;
            while (exp_done.size() != 0 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            check("done_wait", 32'(exp_done.size()), 32'd0);
        end
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int  r0;
        int  t;
        bit  rnw;
        int  nb;
        int  kind;
        logic [LEN_W-1:0] len;
        bus.req_valid = 1'b0;
        bus.req_rnw   = 1'b0;
        bus.req_dev   = '0;
        bus.req_reg   = '0;
        bus.req_wdata = '0;
        bus.req_len   = '0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_status", 32'(bus.status), 32'd0);
        check("rst_cmd", 32'(dut_cmd()), 32'd0);
        rst = 1'b0;

        // Arbitration-lost pulse while idle must be ignored.
        @(negedge clk);
        poke_al = 1'b1;
        repeat (3) @(negedge clk);
        check("al_idle_ready", 32'(bus.req_ready), 32'd1);

        run_txn(0, 7'h50, 8'h10, 8'hA5, '0, -1, -1, 1);
        preset = '{8'h11, 8'h22, 8'h33};
        run_txn(1, 7'h50, 8'h02, 8'h00, LEN_W'(2), -1, -1, 1);
        r0 = rd_count;
        run_txn(1, 7'h50, 8'h02, 8'h00, LEN_W'(2), 0, -1, 1);
        check("nack_no_rd", 32'(rd_count - r0), 32'd0);
        run_txn(0, 7'h50, 8'h10, 8'hA5, '0, 1, -1, 1);
        run_txn(0, 7'h50, 8'h10, 8'hA5, '0, 2, -1, 1);
        run_txn(0, 7'h21, 8'h33, 8'h5A, '0, -1, 1, 1);
        run_txn(1, 7'h21, 8'h33, 8'h00, LEN_W'(3), -1, 4, 1);
        r0 = rd_count;
        run_txn(1, 7'h7F, 8'hFF, 8'h00, '1, -1, -1, 1);
        check("rd_strobes_full_len", 32'(rd_count - r0), 32'(1 << LEN_W));
        r0 = rd_count;
        run_txn(1, 7'h01, 8'h00, 8'h00, '0, -1, -1, 1);
        check("rd_strobes_len0", 32'(rd_count - r0), 32'd1);

        // Reset in the middle of a long read.
        run_txn(1, 7'h2A, 8'h40, 8'h00, '1, -1, -1, 0);
        t = 0;
        while (exp_rd.size() > 12 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid_reached", 32'(exp_rd.size() <= 12), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid_cmd", 32'(dut_cmd()), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        exp_cmd.delete();
        exp_rd.delete();
        exp_done.delete();
        slave_bytes.delete();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        run_txn(0, 7'h50, 8'h10, 8'hA5, '0, -1, -1, 1);

        for (int n = 0; n < 40; n++) begin
            rnw  = 1'($urandom_range(0, 1));
            len  = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
            nb   = rnw ? 4 + int'(len) : 3;
            kind = $urandom_range(0, 9);
            if (kind < 6)      run_txn(rnw, 7'($urandom), 8'($urandom), 8'($urandom), len, -1, -1, 1);
            else if (kind < 8) run_txn(rnw, 7'($urandom), 8'($urandom), 8'($urandom), len, $urandom_range(0, 2), -1, 1);
            else               run_txn(rnw, 7'($urandom), 8'($urandom), 8'($urandom), len, -1, $urandom_range(0, nb - 1), 1);
        end

`ifdef I2C_SEQ_TIMEOUT_EN
        @(negedge clk);
        withhold = 1'b1;
        exp_cmd.push_back(mk(1, 0, 0, 1, 0, {7'h50, 1'b0}));
        exp_done.push_back(2'd3);
        t = 0;
        while (!bus.req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        bus.req_rnw   = 1'b0;
        bus.req_dev   = 7'h50;
        bus.req_reg   = 8'h10;
        bus.req_wdata = 8'hA5;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        t = 0;
        while (exp_done.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("tmo_done", 32'(exp_done.size()), 32'd0);
        check("tmo_not_early", 32'(t >= int'(TMO)), 32'd1);
        check("tmo_not_late", 32'(t <= int'(TMO) + 4), 32'd1);
        withhold = 1'b0;
        repeat (4) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_reg_seq.md
Name: i2c_master_reg_seq

Overview:
- Transaction sequencer that drives the I2C byte controller's command interface (start/stop/read/write/ack_in/din) on behalf of a single requester.
- Turns one register-access request into the full byte sequence:
  - Write: START, device address + W, register address, data byte, STOP.
  - Read: START, device address + W, register address, repeated START, device address + R, N data bytes, STOP.
- Sits between the APB register file and the byte controller; reports completion, NACK, arbitration loss and (optionally) timeout.

Parameters:
- LEN_W, 4: width of the read-length field; one read burst is 1..2^LEN_W bytes.
- TIMEOUT_CYC, 65535: clk cycles allowed per byte command before abort. Used only with I2C_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  master clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle, request accepted when req_valid & req_ready.
- req_rnw  in  1  1 = register read, 0 = register write.
- req_dev  in  7  7-bit slave address.
- req_reg  in  8  register address.
- req_wdata  in  8  write data byte.
- req_len  in  LEN_W  read byte count minus 1.
- rd_valid  out  1  one-cycle strobe, read byte available.
- rd_data  out  8  read byte; valid with rd_valid.
- done  out  1  one-cycle strobe, transaction finished.
- status  out  2  valid with done: 0 OK, 1 NACK, 2 AL, 3 TIMEOUT.
- bc_start, bc_stop, bc_read, bc_write  out  1 each  byte-controller command bits.
- bc_ack_in  out  1  ACK bit the master drives on reads; 0 = ACK, 1 = NACK.
- bc_din  out  8  byte to transmit.
- bc_cmd_ack  in  1  byte-controller command-complete pulse.
- bc_ack_out  in  1  ACK received from slave; 1 = NACK.
- bc_dout  in  8  received byte.
- bc_al  in  1  arbitration lost.

Behaviour:
- Reset values: all outputs 0 except req_ready = 1; state IDLE.
- Outputs are registered. A byte command is held stable until bc_cmd_ack, and all bc_* command bits clear in the cycle after bc_cmd_ack, before the next command is issued. This guarantees at least one idle cycle between commands.
- Request fields are latched on acceptance. req_ready = 0 from the accept cycle until done.
- States and transitions:
  - IDLE: on accept, go to DEVW.
  - DEVW: start+write, din = {dev, 0}. Go to REG.
  - REG: write, din = reg.
    - Write request: go to WDAT.
    - Read request: go to RDEV.
  - WDAT: write+stop, din = wdata. Go to FIN.
  - RDEV: start+write, din = {dev, 1}. Go to RDAT.
  - RDAT: read, with byte counter cnt loaded with req_len.
    - ack_in = 0 while cnt != 0.
    - Last byte (cnt == 0): ack_in = 1 with stop.
    - Each bc_cmd_ack pulses rd_valid with rd_data = bc_dout, then decrements cnt.
    - After the last byte, go to FIN.
  - STOP: stop only; used for NACK recovery. Go to FIN.
  - FIN: pulse done with the latched status, go to IDLE.
- NACK: checked on bc_cmd_ack in DEVW, REG and RDEV, plus WDAT (bc_ack_out = 1).
  - DEVW/REG/RDEV: go to STOP, status = NACK.
  - WDAT: its stop is already issued, so go to FIN with status = NACK.
  - Read-byte ACKs are never checked.
- Arbitration loss: bc_al = 1 in any non-IDLE state has priority over bc_cmd_ack in the same cycle.
  - Clear all bc_* commands; no STOP is issued (the bus is lost).
  - Go to FIN, status = AL.
  - bc_al asserted in IDLE is ignored.
- Counter boundaries:
  - req_len = 0 gives exactly 1 byte.
  - req_len = all-ones gives 2^LEN_W bytes.
  - cnt never wraps.
- Reset mid-transaction: returns to IDLE next cycle with commands deasserted and no done pulse. The byte controller must be reset by the same rst domain.

Optional Feature:
- Macro: I2C_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears whenever a new command is issued and increments while a command is pending.
  - When it reaches TIMEOUT_CYC without bc_cmd_ack: drop all bc_* commands, go to FIN, status = TIMEOUT.
  - bc_al keeps priority over timeout.
- Undefined: no counter logic; status value 3 is never produced.

Decomposition:
- Package i2c_seq_pkg holds:
  - the state enum (IDLE, DEVW, REG, WDAT, RDEV, RDAT, STOP, FIN);
  - status codes ST_OK, ST_NACK, ST_AL, ST_TMO;
  - the R/W bit constants.
- One natural sub-module, i2c_seq_wdog: the timeout counter, instantiated only under I2C_SEQ_TIMEOUT_EN.

Test Plan:
- Write, dev = 0x50, reg = 0x10, wdata = 0xA5, all ACK:
  - bc_din sequence is 0xA0, 0x10, 0xA5;
  - start only on the first command, stop only on the last;
  - done with status 0.
- Read, dev = 0x50, reg = 0x02, req_len = 2, model returns 0x11, 0x22, 0x33:
  - bc_din sequence is 0xA0, 0x02, 0xA1;
  - three rd_valid strobes carrying 0x11, 0x22, 0x33;
  - ack_in pattern 0, 0, 1, with stop on the third read;
  - done with status 0.
- Address NACK (bc_ack_out = 1 after DEVW): one stop-only command, done with status 1, rd_valid never asserted.
- bc_al asserted during REG in the same cycle as bc_cmd_ack: all commands cleared next cycle, no stop, done with status 2.
- req_len = 15: exactly 16 rd_valid strobes; a new request is accepted only after done. rst asserted mid-read: req_ready = 1 next cycle, no done pulse.
- I2C_SEQ_TIMEOUT_EN defined with TIMEOUT_CYC = 100 and bc_cmd_ack withheld: abort after 100 cycles, done with status 3.
